// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded ALU operation at a time to an ALU
// sub-unit, waits for its result, then produces a one-cycle register-file
// writeback and optionally loads the architectural flags register.
// Optional WAIT-state watchdog: define W0RM_ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [3:0]                req_opcode,
  input  logic [DATA_WIDTH-1:0]     req_a,
  input  logic [DATA_WIDTH-1:0]     req_b,
  input  logic [REG_ADDR_WIDTH-1:0] req_dest,
  input  logic                      req_flags_we,
  output logic                      alu_data_valid,
  output logic [3:0]                alu_opcode,
  output logic [DATA_WIDTH-1:0]     alu_data_a,
  output logic [DATA_WIDTH-1:0]     alu_data_b,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_result_valid,
  input  logic [3:0]                alu_result_flags,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_dest,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [3:0]                flags_out,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  // The watchdog needs at least one WAIT cycle before it may fire.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("alu_issue_ctrl: TIMEOUT_CYCLES must be >= 2");
  end

  logic [1:0]                state_q, state_d;
  logic [3:0]                op_q;
  logic [DATA_WIDTH-1:0]     a_q, b_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic                      fwe_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;
  logic [REG_ADDR_WIDTH-1:0] wb_dest_q;
  logic [3:0]                rflags_q;
  logic [3:0]                flags_q;
  logic                      capture;
  logic                      take_res;
  logic                      tmo;

`ifdef W0RM_ALU_ISSUE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          at_limit;
  assign at_limit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic          at_limit;
  assign at_limit = 1'b0;
`endif

  // Next-state decode plus capture strobes for request and result.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    take_res = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (alu_result_valid) begin
          take_res = 1'b1;
          state_d  = S_WB;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result in the limit cycle takes priority over the timeout.
        if (alu_result_valid) begin
          take_res = 1'b1;
          state_d  = S_WB;
        end else if (at_limit) begin
          tmo      = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        if (req_valid) begin
          capture = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State, captured operation, writeback registers and flags register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dest_q    <= '0;
      fwe_q     <= 1'b0;
      wb_data_q <= '0;
      wb_dest_q <= '0;
      rflags_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        op_q   <= req_opcode;
        a_q    <= req_a;
        b_q    <= req_b;
        dest_q <= req_dest;
        fwe_q  <= req_flags_we;
      end
      // Writeback fields are loaded on entry to WB so they hold afterwards
      // even when WB accepts the next operation.
      if (take_res) begin
        wb_data_q <= alu_result;
        wb_dest_q <= dest_q;
        rflags_q  <= alu_result_flags;
      end
      if ((state_q == S_WB) && fwe_q) begin
        flags_q <= rflags_q;
      end
    end
  end

`ifdef W0RM_ALU_ISSUE_TIMEOUT_EN
  // WAIT-cycle counter (zero outside WAIT) and registered timeout pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
      err_q <= tmo;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign req_ready      = (state_q == S_IDLE) || (state_q == S_WB);
  assign busy           = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign alu_data_valid = (state_q == S_ISSUE);
  assign alu_opcode     = op_q;
  assign alu_data_a     = a_q;
  assign alu_data_b     = b_q;
  assign wb_valid       = (state_q == S_WB);
  assign wb_data        = wb_data_q;
  assign wb_dest        = wb_dest_q;
  assign flags_out      = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: an ALU stub (combinational, registered or
// silent) answers issues; expectations come from operation-level rules.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_opcode;
  logic [7:0] req_a, req_b;
  logic [3:0] req_dest;
  logic       req_flags_we;
  logic       alu_data_valid;
  logic [3:0] alu_opcode;
  logic [7:0] alu_data_a, alu_data_b;
  logic [7:0] alu_result;
  logic       alu_result_valid;
  logic [3:0] alu_result_flags;
  logic       wb_valid;
  logic [3:0] wb_dest;
  logic [7:0] wb_data;
  logic [3:0] flags_out;
  logic       busy;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  // 0: single-cycle ALU, 1: registered ALU, 2: never responds
  int   alu_mode = 0;
  logic stray    = 1'b0;
  logic pend_q   = 1'b0;
  logic [11:0] alu_out;
  logic [3:0]  flags_m = 4'h0;

  alu_issue_ctrl #(
    .DATA_WIDTH(8),
    .REG_ADDR_WIDTH(4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .req_dest(req_dest), .req_flags_we(req_flags_we),
    .alu_data_valid(alu_data_valid), .alu_opcode(alu_opcode),
    .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
    .alu_result(alu_result), .alu_result_valid(alu_result_valid),
    .alu_result_flags(alu_result_flags),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .flags_out(flags_out), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {carry, overflow, neg, zero, result}.
  function automatic logic [11:0] alu_fn(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       v, c;
    v = 1'b0;
    c = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd4: r = 8'h00 - a;
      default: r = a - b;
    endcase
    return {c, v, r[7], (r == 8'h00), r};
  endfunction

  always @(posedge clk) pend_q <= (alu_mode == 1) && alu_data_valid;

  always_comb begin
    alu_out          = alu_fn(alu_opcode, alu_data_a, alu_data_b);
    alu_result       = alu_out[7:0];
    alu_result_flags = alu_out[11:8];
    alu_result_valid = stray | ((alu_mode == 0) && alu_data_valid) | pend_q;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one operation from IDLE (called at a negedge) and checks it.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] dest, input logic fwe, input int mode);
    logic [11:0] e;
    int lat, dv, exp_lat;
    alu_mode = mode;
    e = alu_fn(op, a, b);
    exp_lat = (mode == 0) ? 2 : 3;
    chk("ready_before", req_ready, 1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    req_dest = dest; req_flags_we = fwe;
    lat = 0;
    dv = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        chk("issue_dv", alu_data_valid, 1);
        chk("issue_op", alu_opcode, op);
        chk("issue_a", alu_data_a, a);
        chk("issue_b", alu_data_b, b);
        chk("issue_busy", busy, 1);
        chk("issue_ready", req_ready, 0);
      end
      if (alu_data_valid) dv++;
      if (wb_valid) begin
        lat = k;
        chk("wb_data", wb_data, e[7:0]);
        chk("wb_dest", wb_dest, dest);
      end
    end
    chk("latency", lat, exp_lat);
    chk("dv_cycles", dv, 1);
    if (fwe) flags_m = e[11:8];
    @(negedge clk);
    chk("flags_after", flags_out, flags_m);
    chk("wb_low_after", wb_valid, 0);
    chk("wb_data_hold", wb_data, e[7:0]);
    chk("idle_busy", busy, 0);
    chk("idle_ready", req_ready, 1);
    chk("no_err", err_timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] e1, e2;
    int p1, p2, wbc, errk, errc;

    reset_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0;
    req_dest = '0; req_flags_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_dv", alu_data_valid, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_wbdest", wb_dest, 0);
    chk("rst_err", err_timeout, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Registered ALU AND, then single-cycle NEG.
    do_op(4'd0, 8'hF0, 8'h3C, 4'd5, 1'b1, 1);
    chk("and_flags", flags_out, 4'b0000);
    do_op(4'd4, 8'h01, 8'h00, 4'd2, 1'b1, 0);
    chk("neg_flags", flags_out, 4'b0010);

    // Back-to-back, req_valid held; second op does not write flags.
    flags_m = 4'b0000;
    do_op(4'd0, 8'h0F, 8'hF0, 4'd1, 1'b1, 1);
    alu_mode = 1;
    e1 = alu_fn(4'd4, 8'h01, 8'h00);
    e2 = alu_fn(4'd0, 8'h00, 8'h00);
    req_valid = 1'b1; req_opcode = 4'd4; req_a = 8'h01; req_b = 8'h00;
    req_dest = 4'd7; req_flags_we = 1'b1;
    p1 = 0; p2 = 0;
    for (int k = 1; k <= 20 && p2 == 0; k++) begin
      @(negedge clk);
      if (p1 != 0 && k == p1 + 1) begin
        req_valid = 1'b0;
        chk("b2b_flags_next", flags_out, e1[11:8]);
      end
      if (wb_valid) begin
        if (p1 == 0) begin
          p1 = k;
          chk("b2b_data1", wb_data, e1[7:0]);
          chk("b2b_ready_wb", req_ready, 1);
          req_opcode = 4'd0; req_a = 8'h00; req_b = 8'h00;
          req_dest = 4'd9; req_flags_we = 1'b0;
        end else begin
          p2 = k;
          chk("b2b_data2", wb_data, e2[7:0]);
          chk("b2b_dest2", wb_dest, 9);
        end
      end
    end
    chk("b2b_first", p1, 3);
    chk("b2b_gap", p2 - p1, 3);
    flags_m = e1[11:8];
    @(negedge clk);
    chk("b2b_flags_end", flags_out, flags_m);

    // Randomized operations, random ALU latency style.
    for (int i = 0; i < 20; i++) begin
      do_op(4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            4'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    // Reset while waiting on a silent ALU.
    do_op(4'd4, 8'h01, 8'h00, 4'd3, 1'b1, 0);
    alu_mode = 2;
    req_valid = 1'b1; req_opcode = 4'd3; req_a = 8'h11; req_b = 8'h22;
    req_dest = 4'd4; req_flags_we = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_busy", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    flags_m = 4'h0;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", flags_out, 0);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    wbc = 0;
    repeat (4) begin
      @(negedge clk);
      if (wb_valid) wbc++;
    end
    chk("late_result_wb", wbc, 0);

    // Stray result while IDLE with flags set.
    do_op(4'd4, 8'h01, 8'h00, 4'd6, 1'b1, 0);
    stray = 1'b1;
    wbc = 0;
    @(negedge clk);
    stray = 1'b0;
    if (wb_valid) wbc++;
    chk("stray_ready", req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      if (wb_valid) wbc++;
    end
    chk("stray_wb", wbc, 0);
    chk("stray_busy", busy, 0);
    chk("stray_flags", flags_out, 4'b0010);
    chk("stray_wbdata", wb_data, 8'hFF);

`ifdef W0RM_ALU_ISSUE_TIMEOUT_EN
    // Silent ALU: WAIT entered in cycle 2, error pulse 4 cycles later.
    alu_mode = 2;
    req_valid = 1'b1; req_opcode = 4'd1; req_a = 8'h55; req_b = 8'hAA;
    req_dest = 4'd8; req_flags_we = 1'b1;
    errk = 0; errc = 0; wbc = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (err_timeout) begin
        errc++;
        if (errk == 0) errk = k;
      end
      if (wb_valid) wbc++;
    end
    chk("tmo_cycle", errk, 6);
    chk("tmo_pulses", errc, 1);
    chk("tmo_wb", wbc, 0);
    chk("tmo_flags", flags_out, 4'b0010);
    chk("tmo_ready", req_ready, 1);
`else
    alu_mode = 2;
    req_valid = 1'b1; req_opcode = 4'd1; req_a = 8'h55; req_b = 8'hAA;
    req_dest = 4'd8; req_flags_we = 1'b1;
    errc = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (err_timeout) errc++;
    end
    chk("no_tmo_err", errc, 0);
    chk("no_tmo_busy", busy, 1);
    chk("no_tmo_flags", flags_out, 4'b0010);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
